// File: rtl/benes_cfg_loader_if.sv
// Host-side configuration stream for benes_cfg_loader: one word per valid/ready transfer,
// with cfg_last framing the final word of a full-fabric configuration.
interface benes_cfg_loader_if #(
    parameter int WORD_W = 16
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_last;

    modport master (output cfg_valid, output cfg_data, output cfg_last, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_data, input cfg_last, output cfg_ready);
endinterface

// File: rtl/benes_cfg_loader.sv
// Double-buffered switch-setting loader for an N_PORTS Benes fabric.
// Optional feature macro: BENES_CFG_AUTO_COMMIT_EN (a correctly framed last word commits itself).
module benes_cfg_loader #(
    parameter int N_PORTS = 32,
    parameter int WORD_W  = 16,
    localparam int LOG2N      = $clog2(N_PORTS),
    localparam int STAGES     = 2 * LOG2N - 1,
    localparam int SW_PER_STG = N_PORTS / 2,
    localparam int CFG_BITS   = STAGES * SW_PER_STG
) (
    input  logic                 clk,
    input  logic                 rst,
    benes_cfg_loader_if.slave    cfg,
    input  logic                 commit,
    output logic [CFG_BITS-1:0]  switch_set,
    output logic                 cfg_full,
    output logic                 cfg_err
);
    localparam int N_WORDS  = (CFG_BITS + WORD_W - 1) / WORD_W;
    localparam int PAD_BITS = N_WORDS * WORD_W;
    localparam int CNT_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

`ifdef BENES_CFG_AUTO_COMMIT_EN
    localparam bit AUTO_COMMIT = 1'b1;
`else
    localparam bit AUTO_COMMIT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

    state_t                           state;
    state_t                           state_next;
    logic [CNT_W-1:0]                 word_cnt;
    logic [CNT_W-1:0]                 word_cnt_next;
    logic [N_WORDS-1:0][WORD_W-1:0]   shadow;
    logic [N_WORDS-1:0][WORD_W-1:0]   shadow_next;
    logic [PAD_BITS-1:0]              shadow_flat;
    logic                             load_active;
    logic                             err_set;
    logic                             xfer;
    logic                             is_final;

    // Ready is gated by rst so the host sees no acceptance during the reset cycle itself.
    assign cfg.cfg_ready = !rst && (state != FULL);
    assign cfg_full      = (state == FULL);
    assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
    assign is_final      = (word_cnt == LAST_IDX);
    assign shadow_flat   = shadow_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Framing: cfg_last must coincide with the last word index; any mismatch drops the frame.
    always_comb begin
        state_next    = state;
        word_cnt_next = word_cnt;
        shadow_next   = shadow;
        load_active   = 1'b0;
        err_set       = 1'b0;
        case (state)
            IDLE, LOAD: begin
                if (xfer) begin
                    shadow_next[word_cnt] = cfg.cfg_data;
                    if (cfg.cfg_last != is_final) begin
                        err_set       = 1'b1;
                        word_cnt_next = '0;
                        state_next    = IDLE;
                    end else if (is_final) begin
                        word_cnt_next = '0;
                        if (AUTO_COMMIT) begin
                            load_active = 1'b1;
                            state_next  = IDLE;
                        end else begin
                            state_next  = FULL;
                        end
                    end else begin
                        word_cnt_next = word_cnt + 1'b1;
                        state_next    = LOAD;
                    end
                end
            end
            FULL: begin
                if (commit && !AUTO_COMMIT) begin
                    load_active = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt   <= '0;
            shadow     <= '0;
            switch_set <= '0;
            cfg_err    <= 1'b0;
        end else begin
            word_cnt <= word_cnt_next;
            shadow   <= shadow_next;
            if (load_active) begin
                switch_set <= shadow_flat[CFG_BITS-1:0];
            end
            if (err_set) begin
                cfg_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_benes_cfg_loader.sv
// Scoreboard bench for benes_cfg_loader: the driver pushes one expected output snapshot per
// cycle from a frame-level model; an independent monitor pops and compares.
module tb_benes_cfg_loader;
    localparam int N_PORTS  = 32;
    localparam int WORD_W   = 16;
    localparam int LOG2N    = $clog2(N_PORTS);
    localparam int CFG_BITS = (2 * LOG2N - 1) * (N_PORTS / 2);
    localparam int N_WORDS  = (CFG_BITS + WORD_W - 1) / WORD_W;

`ifdef BENES_CFG_AUTO_COMMIT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                commit = 1'b0;
    logic [CFG_BITS-1:0] switch_set;
    logic                cfg_full;
    logic                cfg_err;

    benes_cfg_loader_if #(.WORD_W(WORD_W)) cfg_bus ();

    benes_cfg_loader #(.N_PORTS(N_PORTS), .WORD_W(WORD_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg       (cfg_bus),
        .commit    (commit),
        .switch_set(switch_set),
        .cfg_full  (cfg_full),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                  due;
        logic [CFG_BITS-1:0] sw;
        bit                  ready;
        bit                  full;
        bit                  err;
    } exp_t;

    exp_t exp_q[$];
    int   checks_total  = 0;
    int   checks_passed = 0;

    // Frame-level reference: accepted words queue up until a frame completes or breaks.
    logic [WORD_W-1:0]   m_words[$];
    bit                  m_full = 1'b0;
    bit                  m_err  = 1'b0;
    logic [CFG_BITS-1:0] m_active  = '0;
    logic [CFG_BITS-1:0] m_pending = '0;
    logic [WORD_W-1:0]   frame_words[N_WORDS];

    function automatic logic [CFG_BITS-1:0] pack_words();
        logic [N_WORDS*WORD_W-1:0] wide;
        wide = '0;
        for (int k = 0; k < N_WORDS; k++) wide[k*WORD_W +: WORD_W] = m_words[k];
        return wide[CFG_BITS-1:0];
    endfunction

    task automatic apply_stimulus(input bit r, input bit v, input logic [WORD_W-1:0] d,
                                  input bit l, input bit c, input bit record = 1'b1);
        exp_t e;
        @(negedge clk);
        rst               = r;
        cfg_bus.cfg_valid = v;
        cfg_bus.cfg_data  = d;
        cfg_bus.cfg_last  = l;
        commit            = c;
        if (record) begin
            e.due   = cyc;
            e.sw    = m_active;
            e.ready = !r && !m_full;
            e.full  = m_full;
            e.err   = m_err;
            exp_q.push_back(e);
        end
        if (r) begin
            m_words.delete();
            m_full   = 1'b0;
            m_err    = 1'b0;
            m_active = '0;
        end else if (m_full) begin
            if (c) begin
                m_active = m_pending;
                m_full   = 1'b0;
            end
        end else if (v) begin
            m_words.push_back(d);
            if (l != (m_words.size() == N_WORDS)) begin
                m_err = 1'b1;
                m_words.delete();
            end else if (m_words.size() == N_WORDS) begin
                m_pending = pack_words();
                m_words.delete();
                if (AUTO) m_active = m_pending;
                else      m_full   = 1'b1;
            end
        end
    endtask

    task automatic check_output(input string name, input logic [CFG_BITS-1:0] got,
                                input logic [CFG_BITS-1:0] want);
        checks_total++;
        if (got === want) checks_passed++;
        else $display("[TB] FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    endtask

    task automatic idle(input int n);
        repeat (n) apply_stimulus(1'b0, 1'b0, WORD_W'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic do_commit();
        apply_stimulus(1'b0, 1'b0, WORD_W'($urandom), 1'b0, 1'b1);
    endtask

    task automatic hold_reset();
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // bad: -1 framed correctly, 0..N_WORDS-2 early last there, N_WORDS-1 last missing.
    task automatic send_frame(input int bad, input bit gaps, input int commit_after,
                              input int reset_after);
        bit last;
        for (int k = 0; k < N_WORDS; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2))
                    apply_stimulus(1'b0, 1'b0, WORD_W'($urandom), 1'($urandom),
                                   $urandom_range(0, 4) == 0);
            end
            if (bad < 0)                last = (k == N_WORDS - 1);
            else if (bad == N_WORDS-1)  last = 1'b0;
            else                        last = (k == bad);
            apply_stimulus(1'b0, 1'b1, frame_words[k], last, 1'b0);
            if (k == commit_after) do_commit();
            if (k == reset_after) begin
                hold_reset();
                return;
            end
            if (bad >= 0 && k == bad) return;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                check_output("switch_set", switch_set, e.sw);
                check_output("cfg_ready", CFG_BITS'(cfg_bus.cfg_ready), CFG_BITS'(e.ready));
                check_output("cfg_full", CFG_BITS'(cfg_full), CFG_BITS'(e.full));
                check_output("cfg_err", CFG_BITS'(cfg_err), CFG_BITS'(e.err));
            end
        end
    end

    initial begin : driver
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_data  = '0;
        cfg_bus.cfg_last  = 1'b0;
        $display("[TB] start, auto_commit=%0d", AUTO);

        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        idle(3);

        for (int k = 0; k < N_WORDS; k++) frame_words[k] = 16'hFFFF;
        send_frame(-1, 1'b0, -1, -1);
        idle(2);
        do_commit();
        idle(2);

        // While FULL the host keeps valid high; nothing may transfer.
        for (int k = 0; k < N_WORDS; k++) frame_words[k] = 16'h0001 << k;
        send_frame(-1, 1'b0, -1, -1);
        repeat (20) apply_stimulus(1'b0, m_full, WORD_W'($urandom), 1'($urandom), 1'b0);
        do_commit();
        idle(2);

        for (int k = 0; k < N_WORDS; k++) frame_words[k] = WORD_W'(16'h1111 * (k + 1));
        send_frame(4, 1'b0, -1, -1);
        idle(2);
        send_frame(N_WORDS - 1, 1'b0, -1, -1);
        idle(1);
        for (int k = 0; k < N_WORDS; k++) frame_words[k] = WORD_W'($urandom);
        send_frame(-1, 1'b0, -1, -1);
        idle(1);
        do_commit();
        idle(2);

        for (int k = 0; k < N_WORDS; k++) frame_words[k] = WORD_W'($urandom);
        send_frame(-1, 1'b0, 3, -1);
        idle(1);
        do_commit();
        idle(2);
        send_frame(-1, 1'b0, -1, 5);
        idle(2);
        for (int k = 0; k < N_WORDS; k++) frame_words[k] = WORD_W'($urandom);
        send_frame(-1, 1'b0, -1, -1);
        do_commit();
        idle(2);

        for (int k = 0; k < N_WORDS; k++) frame_words[k] = 16'hA5A5;
        send_frame(-1, 1'b0, -1, -1);
        idle(3);
        do_commit();
        idle(2);

        for (int f = 0; f < 25; f++) begin
            int bad;
            for (int k = 0; k < N_WORDS; k++) frame_words[k] = WORD_W'($urandom);
            bad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, N_WORDS - 1)) : -1;
            send_frame(bad, 1'b1, -1, -1);
            repeat ($urandom_range(0, 3))
                apply_stimulus(1'b0, m_full, WORD_W'($urandom), 1'($urandom), 1'b0);
            if (m_full || $urandom_range(0, 1) == 1) do_commit();
        end

        idle(3);
        @(negedge clk);
        #2;
        checks_total++;
        if (exp_q.size() == 0) checks_passed++;
        else $display("[TB] FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
